hex_scan_driver: RTL and testbench
==================================

// Module: hex_scan_driver
// PURPOSE
//  Downstream display stage: takes the 32-bit hex value produced by cnt2hex/counter logic and
//  time-multiplexes it onto the 8-digit common-anode 7-segment display (CA..CG, DP, AN).
//  Value/DP updates are double-buffered and committed only at frame boundaries (no tearing).
//  Optional leading-zero blanking. Single clock domain, registered outputs.
// PARAMETERS
//  DIGIT_TICKS  100_000  clk cycles each digit stays lit (1 ms @ 100 MHz); sim uses 4
//  NUM_DIGITS   8        digits scanned; value_i holds 4*NUM_DIGITS bits
//  BLANK_LZ     1        1 = blank leading zero digits (digit 0 never blanked)
// PORTS
//  clk_100MHz_i  in   1   system clock
//  rst_i         in   1   synchronous, active-high reset
//  en_i          in   1   1 = scan runs; 0 = scan frozen, display dark
//  value_i       in   32  hex value, nibble k -> digit k (digit 0 = rightmost)
//  dp_i          in   8   decimal point per digit, 1 = lit
//  load_i        in   1   1-cycle strobe: capture value_i/dp_i into shadow
//  pending_o     out  1   shadow holds data not yet committed to display
//  frame_o       out  1   1-cycle pulse when the last digit's slot ends (frame boundary)
//  seg_o         out  7   {CG,CF,CE,CD,CC,CB,CA}, active-low
//  dp_o          out  1   DP, active-low
//  an_o          out  8   anode enables, active-low, an_o[k] = digit k
// BEHAVIOUR
//  Reset (rst_i=1, sync, overrides all): tick_cnt=0, dig_idx=0, shadow=0, disp=0, pending_o=0,
//   frame_o=0, an_o=8'hFF, seg_o=7'h7F, dp_o=1. Reset mid-frame discards shadow and pending.
//  Timing: tick_cnt counts 0..DIGIT_TICKS-1 while en_i=1, wraps; tick = en_i & (tick_cnt==DIGIT_TICKS-1).
//   On tick dig_idx increments mod NUM_DIGITS. Frame boundary = tick & dig_idx==NUM_DIGITS-1;
//   frame_o is high exactly that cycle.
//  Load: load_i=1 -> shadow<=value_i/dp_i, pending_o<=1 next cycle. Later loads before a boundary
//   overwrite shadow (last wins).
//  Commit: at a boundary with pending_o=1 -> disp<=shadow, pending_o<=0. First frame scanning the new
//   value begins with digit 0 on the following cycle.
//  Simultaneous load_i & boundary: disp<=old shadow (if pending), shadow<=new value, pending_o stays 1.
//  Outputs registered: an_o/seg_o/dp_o reflect dig_idx/disp of the previous cycle (latency 1).
//   an_o = ~(1<<dig_idx); seg_o = decode(disp nibble dig_idx); dp_o = ~disp_dp[dig_idx].
//  Blanking: BLANK_LZ=1 and k>0 and nibbles k..NUM_DIGITS-1 all zero -> seg_o=7'h7F for digit k
//   (anode still driven); dp_o unaffected by blanking.
//  Decode (active-low, {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46
//   d=21 E=06 F=0E (hex).
//  en_i=0: tick_cnt/dig_idx hold, an_o=8'hFF next cycle, frame_o=0; load/pending still operate;
//   en_i back to 1 resumes from held tick_cnt/dig_idx.
//  tick_cnt width = $clog2(DIGIT_TICKS); dig_idx width = $clog2(NUM_DIGITS); no overflow paths.
// TESTING (DIGIT_TICKS=4)
//  1 Reset: rst_i=1 2 cycles -> an_o=FF, seg_o=7F, dp_o=1, pending_o=0; release, en_i=1 -> an_o
//    walks FE,FD,..,7F every 4 cycles, frame_o pulses every 32 cycles.
//  2 Load 0x000000A5, dp_i=01 mid-frame -> pending_o=1 until next frame_o, then digit0 seg=12,
//    dp_o=0; digit1 seg=08; digits 2..7 seg=7F (blanked).
//  3 BLANK_LZ=0, load 0x00000000 -> all 8 digits seg=40; load 0x80000000 -> digit7=00, others 40.
//  4 Load X, then load_i exactly on frame_o cycle with Y -> next frame shows X, pending_o=1,
//    frame after shows Y, pending_o=0.
//  5 en_i=0 for 10 cycles mid-digit 3 -> an_o=FF, dig_idx held; en_i=1 -> digit 3 resumes, slot
//    completes remaining ticks.
//  6 rst_i mid-frame with pending_o=1 -> all outputs to reset values, shadow lost, disp=0.

Source files
------------

// File: rtl/hex_scan_driver.sv
// hex_scan_driver
//   Time-multiplexes a packed hex value onto a common-anode 7-segment display.
//   The value and the decimal points are double-buffered. A load captures them
//   into a shadow register, and the shadow is committed to the displayed copy
//   only at a frame boundary, so a frame never shows a mix of old and new data.
//   Leading zero digits can be blanked. All display outputs are registered.
//
// Ports
//   clk_100MHz_i  in   system clock
//   rst_i         in   synchronous active-high reset, overrides everything
//   en_i          in   1 = scan runs; 0 = scan frozen and display dark
//   value_i       in   4*NUM_DIGITS  hex value, nibble k drives digit k (digit 0 rightmost)
//   dp_i          in   NUM_DIGITS    decimal point per digit, 1 = lit
//   load_i        in   1-cycle strobe that captures value_i/dp_i into the shadow
//   pending_o     out  shadow holds data not yet committed to the display
//   frame_o       out  high for the single cycle in which the last digit's slot ends
//   seg_o         out  {CG,CF,CE,CD,CC,CB,CA}, active-low
//   dp_o          out  DP, active-low
//   an_o          out  NUM_DIGITS  anode enables, active-low, an_o[k] = digit k
module hex_scan_driver #(
  parameter int DIGIT_TICKS = 100_000,
  parameter int NUM_DIGITS  = 8,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                    clk_100MHz_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  output logic                    pending_o,
  output logic                    frame_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [IW-1:0] DIG_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Bit k set when digit k is a leading zero: k > 0 and every nibble from k
  // up to the most significant one is zero. Digit 0 is never blanked so a
  // zero value still shows a single "0".
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic zero_above;
    m          = '0;
    zero_above = 1'b1;
    if (BLANK_LZ) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        zero_above = zero_above && (v[4*k +: 4] == 4'h0);
        m[k]       = zero_above;
      end
    end
    return m;
  endfunction

  logic [TW-1:0]           tick_cnt_q,   tick_cnt_d;
  logic [IW-1:0]           dig_idx_q,    dig_idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q,   disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;
  logic                    pending_q,    pending_d;
  logic [NUM_DIGITS-1:0]   an_q,         an_d;
  logic [6:0]              seg_q,        seg_d;
  logic                    dp_q,         dp_d;

  logic                    tick;
  logic                    boundary;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   blank_mask;

  always_comb begin
    tick         = en_i && (tick_cnt_q == TICK_LAST);
    boundary     = tick && (dig_idx_q == DIG_LAST);

    tick_cnt_d   = tick_cnt_q;
    dig_idx_d    = dig_idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    cur_nib      = disp_val_q[4*int'(dig_idx_q) +: 4];
    blank_mask   = lz_mask(disp_val_q);

    // Scan timing only advances while enabled; disabling freezes the position.
    if (en_i) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end
    if (tick) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
    end

    // Commit reads the old shadow before a same-cycle load replaces it, so a
    // load landing on the boundary stays pending for the following frame.
    if (boundary && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end
    if (load_i) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
      pending_d    = 1'b1;
    end

    // Drive the digit selected this cycle; outputs appear one cycle later.
    if (en_i) begin
      an_d  = ~(AN_ONE << dig_idx_q);
      seg_d = blank_mask[dig_idx_q] ? 7'h7F : seg_decode(cur_nib);
      dp_d  = ~disp_dp_q[dig_idx_q];
    end
  end

  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      tick_cnt_q   <= '0;
      dig_idx_q    <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign pending_o = pending_q;
  assign frame_o   = boundary && !rst_i;
  assign an_o      = an_q;
  assign seg_o     = seg_q;
  assign dp_o      = dp_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with DIGIT_TICKS=4. Two instances share the inputs:
// dut_a blanks leading zeros, dut_b does not. A behavioural model derives the
// scan position from the number of enabled cycles since reset and tracks the
// shadow/displayed values as plain variables.
module tb_hex_scan_driver;

  localparam int T = 4;
  localparam int N = 8;

  logic [6:0] seg_lut [16];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, load;
  logic [31:0] value;
  logic [7:0]  dp;

  logic       pend_a, frame_a, dpo_a, pend_b, frame_b, dpo_b;
  logic [6:0] seg_a, seg_b;
  logic [7:0] an_a, an_b;

  hex_scan_driver #(.DIGIT_TICKS(T), .NUM_DIGITS(N), .BLANK_LZ(1'b1)) dut_a (
    .clk_100MHz_i(clk), .rst_i(rst), .en_i(en), .value_i(value), .dp_i(dp),
    .load_i(load), .pending_o(pend_a), .frame_o(frame_a), .seg_o(seg_a),
    .dp_o(dpo_a), .an_o(an_a));

  hex_scan_driver #(.DIGIT_TICKS(T), .NUM_DIGITS(N), .BLANK_LZ(1'b0)) dut_b (
    .clk_100MHz_i(clk), .rst_i(rst), .en_i(en), .value_i(value), .dp_i(dp),
    .load_i(load), .pending_o(pend_b), .frame_o(frame_b), .seg_o(seg_b),
    .dp_o(dpo_b), .an_o(an_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          en_cnt;
  logic [31:0] m_shadow, m_disp;
  logic [7:0]  m_shadow_dp, m_disp_dp;
  bit          m_pend;
  logic [7:0]  e_an;
  logic [6:0]  e_seg_a, e_seg_b;
  logic        e_dp;
  bit          chk_on = 1'b0;
  int          m_dg;
  bit          m_bnd;

  function automatic bit is_boundary(input logic en_v, input int cnt);
    return en_v && (cnt % T == T - 1) && ((cnt / T) % N == N - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      en_cnt = 0; m_shadow = 0; m_disp = 0; m_shadow_dp = 0; m_disp_dp = 0;
      m_pend = 0; e_an = 8'hFF; e_seg_a = 7'h7F; e_seg_b = 7'h7F; e_dp = 1'b1;
      chk_on = 1'b1;
    end else begin
      m_dg  = (en_cnt / T) % N;
      m_bnd = is_boundary(en, en_cnt);
      if (en) begin
        e_an    = ~(8'h01 << m_dg);
        e_seg_b = seg_lut[(m_disp >> (4 * m_dg)) & 32'hF];
        e_seg_a = (m_dg > 0 && (m_disp >> (4 * m_dg)) == 0) ? 7'h7F : e_seg_b;
        e_dp    = ~m_disp_dp[m_dg];
      end else begin
        e_an = 8'hFF;
      end
      if (m_bnd && m_pend) begin
        m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pend = 0;
      end
      if (load) begin
        m_shadow = value; m_shadow_dp = dp; m_pend = 1;
      end
      if (en) en_cnt++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("pending_a", pend_a, m_pend);
      check("pending_b", pend_b, m_pend);
      check("frame_a", frame_a, !rst && is_boundary(en, en_cnt));
      check("frame_b", frame_b, !rst && is_boundary(en, en_cnt));
      check("an_a", an_a, e_an);
      check("an_b", an_b, e_an);
      if (e_an != 8'hFF) begin
        check("seg_a", seg_a, e_seg_a);
        check("seg_b", seg_b, e_seg_b);
        check("dp_a", dpo_a, e_dp);
        check("dp_b", dpo_b, e_dp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frame(input string nm, output int k);
    k = 0;
    while (frame_a !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check(nm, frame_a, 1'b1);
  endtask

  task automatic wait_an(input string nm, input logic [7:0] target);
    int k;
    k = 0;
    while (an_a !== target && k < 100) begin
      step();
      k++;
    end
    check(nm, an_a, target);
  endtask

  initial begin
    int k;
    seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp = '0;

    // Reset state
    step(); step();
    check("rst_an", an_a, 8'hFF);
    check("rst_seg", seg_a, 7'h7F);
    check("rst_dp", dpo_a, 1'b1);
    check("rst_pending", pend_a, 1'b0);

    // Scan walk and frame period
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      if (i == 1)  check("walk_d0", an_a, 8'hFE);
      if (i == 5)  check("walk_d1", an_a, 8'hFD);
      if (i == 29) check("walk_d7", an_a, 8'h7F);
      if (i == 30) check("walk_noframe", frame_a, 1'b0);
      if (i == 31) check("walk_frame", frame_a, 1'b1);
      if (i == 33) check("walk_wrap", an_a, 8'hFE);
    end
    wait_frame("frame_first", k);
    step();
    wait_frame("frame_second", k);
    check("frame_period", k + 1, 32);

    // Load 0x000000A5 mid-frame with dp on digit 0
    repeat (10) step();
    value = 32'h0000_00A5; dp = 8'h01; load = 1'b1;
    step();
    load = 1'b0;
    check("a5_pending", pend_a, 1'b1);
    wait_frame("a5_frame", k);
    check("a5_pending_at_frame", pend_a, 1'b1);
    step();
    check("a5_committed", pend_a, 1'b0);
    step();
    check("a5_d0_an", an_a, 8'hFE);
    check("a5_d0_seg", seg_a, 7'h12);
    check("a5_d0_dp", dpo_a, 1'b0);
    repeat (4) step();
    check("a5_d1_seg", seg_a, 7'h08);
    check("a5_d1_dp", dpo_a, 1'b1);
    repeat (4) step();
    check("a5_d2_blank", seg_a, 7'h7F);
    check("a5_d2_noblank", seg_b, 7'h40);

    // 0x80000000: digit 7 shows 8, digits below are zeros (blanked only in dut_a? no: not leading)
    value = 32'h8000_0000; dp = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame("h8_frame", k);
    step(); step();
    repeat (24) step();
    check("h8_d6_a", seg_a, 7'h40);
    check("h8_d6_b", seg_b, 7'h40);
    repeat (4) step();
    check("h8_d7_a", seg_a, 7'h00);
    check("h8_d7_b", seg_b, 7'h00);

    // Load X, then load Y exactly on the boundary
    repeat (5) step();
    value = 32'h1234_5678; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame("xy_frame1", k);
    value = 32'h9ABC_DEF0; load = 1'b1;
    step();
    load = 1'b0;
    check("xy_still_pending", pend_a, 1'b1);
    step();
    check("xy_x_d0", seg_a, 7'h00);
    wait_frame("xy_frame2", k);
    step();
    check("xy_y_committed", pend_a, 1'b0);
    step();
    check("xy_y_d0", seg_a, 7'h40);
    check("xy_y_d0_b", seg_b, 7'h40);

    // Freeze during digit 3
    wait_an("freeze_reach_d3", 8'hF7);
    step();
    en = 1'b0;
    step();
    check("freeze_dark", an_a, 8'hFF);
    check("freeze_noframe", frame_a, 1'b0);
    repeat (9) step();
    check("freeze_dark_end", an_a, 8'hFF);
    en = 1'b1;
    step();
    check("freeze_resume_d3", an_a, 8'hF7);

    // Reset with pending data
    value = 32'hFFFF_FFFF; dp = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    check("rst2_pending_before", pend_a, 1'b1);
    rst = 1'b1;
    step();
    check("rst2_pending", pend_a, 1'b0);
    check("rst2_an", an_a, 8'hFF);
    check("rst2_seg", seg_a, 7'h7F);
    rst = 1'b0;
    wait_frame("rst2_frame", k);
    step();
    check("rst2_no_commit", pend_a, 1'b0);
    step();
    check("rst2_disp_zero", seg_b, 7'h40);
    check("rst2_dp_off", dpo_b, 1'b1);

    // Randomised phase
    for (int i = 0; i < 3000; i++) begin
      step();
      rst   = ($urandom_range(0, 599) == 0);
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 19) == 0);
      value = $urandom >> (4 * $urandom_range(0, 7));
      dp    = 8'($urandom);
      #1;
      if (frame_a === 1'b1 && $urandom_range(0, 2) == 0) load = 1'b1;
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
